vectored_irq_ctrl: RTL and testbench

- Vectored interrupt controller for the 8-bit non-pipelined core.
- Latches edge-triggered interrupt requests and masks them.
- Arbitrates pending requests by fixed priority, with in-service nesting.
- Hands the CPU a PC vector at an instruction boundary through a req/ack handshake. Sits between the peripherals and the CPU's program counter.

---
 rtl/vectored_irq_ctrl_if.sv | 27 ++
 rtl/vectored_irq_ctrl.sv | 149 ++++++++++++++
 tb/tb_vectored_irq_ctrl.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/vectored_irq_ctrl_if.sv
// CPU-side bus of the vectored interrupt controller: configuration writes,
// the instruction-boundary/ack/iret handshake, and the vector hand-off.
interface vectored_irq_ctrl_if #(
    parameter int unsigned PC_W = 4
);
    logic            cfg_we;
    logic [3:0]      cfg_addr;
    logic [7:0]      cfg_wdata;
    logic            boundary;
    logic            irq_ack;
    logic            iret;
    logic            irq_req;
    logic [PC_W-1:0] vector;
    logic            vec_valid;

    // CPU / configuration master
    modport master (
        output cfg_we, cfg_addr, cfg_wdata, boundary, irq_ack, iret,
        input  irq_req, vector, vec_valid
    );

    // Interrupt controller
    modport slave (
        input  cfg_we, cfg_addr, cfg_wdata, boundary, irq_ack, iret,
        output irq_req, vector, vec_valid
    );
endinterface

// File: rtl/vectored_irq_ctrl.sv
// Vectored interrupt controller: edge-latched requests, maskable, fixed
// priority (index 0 highest) with in-service nesting, and a req/ack hand-off
// of the handler address at a CPU instruction boundary.
module vectored_irq_ctrl #(
    parameter int unsigned N_IRQ = 4,
    parameter int unsigned PC_W  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_IRQ-1:0]     irq_in,
    vectored_irq_ctrl_if.slave   bus,
    output logic [N_IRQ-1:0]     pending,
    output logic [N_IRQ-1:0]     in_service
);
    localparam int unsigned ID_W     = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;
    localparam int unsigned TAB_SIZE = 32'(1) << PC_W;

    typedef enum logic [1:0] {IDLE, REQ, ACK} state_t;

    state_t            state, state_nxt;
    logic [ID_W-1:0]   sel_id, sel_id_nxt, sel;
    logic [N_IRQ-1:0]  s1, s2, p;
    logic [N_IRQ-1:0]  mask;
    logic [PC_W-1:0]   vec_tab [N_IRQ];
    logic [N_IRQ-1:0]  edge_set, allowed, eligible, sel_oh, ack_clr, iret_clr;
    logic [N_IRQ-1:0]  pending_nxt, in_service_nxt;
    logic              blocked;
    logic [PC_W-1:0]   vec_cur;
    logic              irq_req_q, irq_req_nxt;
    logic              vec_valid_q, vec_valid_nxt;
    logic [PC_W-1:0]   vector_q, vector_nxt;
    logic              unused_wdata;

    // Upper write-data bits are not used by narrow configurations.
    assign unused_wdata = ^bus.cfg_wdata;

    assign bus.irq_req   = irq_req_q;
    assign bus.vec_valid = vec_valid_q;
    assign bus.vector    = vector_q;

    // Input synchronizers, edge history, mask and vector table.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1   <= '0;
            s2   <= '0;
            p    <= '0;
            mask <= '1;
            for (int i = 0; i < int'(N_IRQ); i++)
                vec_tab[i] <= PC_W'(TAB_SIZE - N_IRQ + unsigned'(i));
        end else begin
            s1 <= irq_in;
            s2 <= s1;
            p  <= s2;
            if (bus.cfg_we) begin
                if (bus.cfg_addr == 4'(N_IRQ))
                    mask <= bus.cfg_wdata[N_IRQ-1:0];
                for (int i = 0; i < int'(N_IRQ); i++)
                    if (bus.cfg_addr == 4'(i))
                        vec_tab[i] <= bus.cfg_wdata[PC_W-1:0];
            end
        end
    end

    // Eligibility under nesting, fixed-priority select and table read.
    always_comb begin
        edge_set = s2 & ~p;
        allowed  = '0;
        blocked  = 1'b0;
        for (int i = 0; i < int'(N_IRQ); i++) begin
            if (in_service[i])
                blocked = 1'b1;
            allowed[i] = ~blocked;
        end
        eligible = pending & ~mask & allowed;
        sel      = '0;
        for (int i = int'(N_IRQ) - 1; i >= 0; i--)
            if (eligible[i])
                sel = ID_W'(i);
        sel_oh  = N_IRQ'(1) << sel_id;
        vec_cur = '0;
        for (int i = 0; i < int'(N_IRQ); i++)
            if (sel_id == ID_W'(i))
                vec_cur = vec_tab[i];
        // Lowest set bit = highest-priority handler in service.
        iret_clr = in_service & (~in_service + N_IRQ'(1));
    end

    // Next state and next registered outputs of the handshake FSM.
    always_comb begin
        state_nxt     = state;
        sel_id_nxt    = sel_id;
        irq_req_nxt   = irq_req_q;
        vec_valid_nxt = 1'b0;
        vector_nxt    = vector_q;
        ack_clr       = '0;
        case (state)
            IDLE: begin
                if (bus.boundary && (eligible != '0)) begin
                    state_nxt   = REQ;
                    sel_id_nxt  = sel;
                    irq_req_nxt = 1'b1;
                end
            end
            REQ: begin
                if (bus.irq_ack) begin
                    state_nxt     = ACK;
                    irq_req_nxt   = 1'b0;
                    vec_valid_nxt = 1'b1;
                    vector_nxt    = vec_cur;
                    ack_clr       = sel_oh;
                end else if ((mask & sel_oh) != '0) begin
                    state_nxt   = IDLE;
                    irq_req_nxt = 1'b0;
                end
            end
            ACK: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt   = IDLE;
                irq_req_nxt = 1'b0;
            end
        endcase
        // A fresh edge wins over the acceptance clear; iret sees the old value.
        pending_nxt    = (pending & ~ack_clr) | edge_set;
        in_service_nxt = (bus.iret ? (in_service & ~iret_clr) : in_service) | ack_clr;
    end

    // State register and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            sel_id      <= '0;
            irq_req_q   <= 1'b0;
            vec_valid_q <= 1'b0;
            vector_q    <= '0;
            pending     <= '0;
            in_service  <= '0;
        end else begin
            state       <= state_nxt;
            sel_id      <= sel_id_nxt;
            irq_req_q   <= irq_req_nxt;
            vec_valid_q <= vec_valid_nxt;
            vector_q    <= vector_nxt;
            pending     <= pending_nxt;
            in_service  <= in_service_nxt;
        end
    end
endmodule

// File: tb/tb_vectored_irq_ctrl.sv
// Directed bench for vectored_irq_ctrl with hand-computed expectations.
module tb_vectored_irq_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] irq_in;
    logic [3:0] pending;
    logic [3:0] in_service;
    int         checks   = 0;
    int         failures = 0;

    vectored_irq_ctrl_if #(.PC_W(4)) bus ();

    vectored_irq_ctrl #(.N_IRQ(4), .PC_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .irq_in     (irq_in),
        .bus        (bus),
        .pending    (pending),
        .in_service (in_service)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [3:0] a, input logic [7:0] d);
        bus.cfg_we = 1'b1; bus.cfg_addr = a; bus.cfg_wdata = d;
        step();
        bus.cfg_we = 1'b0;
    endtask

    // Pulse lands in pending after the third edge.
    task automatic pulse_irq(input logic [3:0] b);
        irq_in = b;
        step();
        irq_in = 4'b0000;
        step();
        step();
    endtask

    task automatic pulse_boundary;
        bus.boundary = 1'b1; step(); bus.boundary = 1'b0;
    endtask

    task automatic pulse_ack;
        bus.irq_ack = 1'b1; step(); bus.irq_ack = 1'b0;
    endtask

    task automatic pulse_iret;
        bus.iret = 1'b1; step(); bus.iret = 1'b0;
    endtask

    task automatic start;
        rst = 1'b1; step(); step(); rst = 1'b0;
        cfg_write(4'd4, 8'h00);
    endtask

    task automatic test_reset;
        rst = 1'b1; step(); step(); rst = 1'b0;
        checks++;
        if ({bus.irq_req, bus.vec_valid, bus.vector, pending, in_service} !== 15'h0) begin
            failures++;
            $display("FAIL reset_outputs got=%0h exp=0", {bus.irq_req, bus.vec_valid, bus.vector, pending, in_service});
        end
    endtask

    task automatic test_basic;
        start();
        pulse_irq(4'b0100);
        checks++;
        if (pending !== 4'b0100) begin failures++; $display("FAIL basic_pending got=%b exp=0100", pending); end
        pulse_boundary();
        checks++;
        if (bus.irq_req !== 1'b1) begin failures++; $display("FAIL basic_irq_req got=%b exp=1", bus.irq_req); end
        checks++;
        if (bus.vec_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid got=%b exp=0", bus.vec_valid); end
        pulse_ack();
        checks++;
        if ({bus.vec_valid, bus.irq_req, bus.vector} !== {1'b1, 1'b0, 4'd14}) begin
            failures++; $display("FAIL basic_ack got=%b/%b/%0d exp=1/0/14", bus.vec_valid, bus.irq_req, bus.vector);
        end
        checks++;
        if ({pending, in_service} !== {4'b0000, 4'b0100}) begin
            failures++; $display("FAIL basic_regs got=%b/%b exp=0000/0100", pending, in_service);
        end
        step();
        checks++;
        if (bus.vec_valid !== 1'b0) begin failures++; $display("FAIL basic_valid_drop got=%b exp=0", bus.vec_valid); end
    endtask

    task automatic test_priority;
        start();
        pulse_irq(4'b1010);
        pulse_boundary();
        pulse_ack();
        checks++;
        if ({bus.vector, pending, in_service} !== {4'd13, 4'b1000, 4'b0010}) begin
            failures++; $display("FAIL prio_first got=%0d/%b/%b exp=13/1000/0010", bus.vector, pending, in_service);
        end
        step();
        pulse_boundary();
        checks++;
        if (bus.irq_req !== 1'b0) begin failures++; $display("FAIL prio_nest_block got=%b exp=0", bus.irq_req); end
        step();
        checks++;
        if (bus.irq_req !== 1'b0) begin failures++; $display("FAIL prio_nest_block2 got=%b exp=0", bus.irq_req); end
        pulse_iret();
        checks++;
        if (in_service !== 4'b0000) begin failures++; $display("FAIL prio_iret got=%b exp=0000", in_service); end
        pulse_boundary();
        checks++;
        if (bus.irq_req !== 1'b1) begin failures++; $display("FAIL prio_second_req got=%b exp=1", bus.irq_req); end
        pulse_ack();
        checks++;
        if ({bus.vec_valid, bus.vector, pending, in_service} !== {1'b1, 4'd15, 4'b0000, 4'b1000}) begin
            failures++; $display("FAIL prio_second got=%b/%0d/%b/%b exp=1/15/0000/1000", bus.vec_valid, bus.vector, pending, in_service);
        end
    endtask

    task automatic test_nesting;
        start();
        pulse_irq(4'b0100);
        pulse_boundary();
        pulse_ack();
        pulse_irq(4'b0001);
        pulse_boundary();
        checks++;
        if (bus.irq_req !== 1'b1) begin failures++; $display("FAIL nest_preempt_req got=%b exp=1", bus.irq_req); end
        pulse_ack();
        checks++;
        if ({bus.vector, in_service} !== {4'd12, 4'b0101}) begin
            failures++; $display("FAIL nest_preempt got=%0d/%b exp=12/0101", bus.vector, in_service);
        end
        pulse_iret();
        checks++;
        if (in_service !== 4'b0100) begin failures++; $display("FAIL nest_iret1 got=%b exp=0100", in_service); end
        pulse_iret();
        checks++;
        if (in_service !== 4'b0000) begin failures++; $display("FAIL nest_iret2 got=%b exp=0000", in_service); end
        pulse_iret();
        checks++;
        if (in_service !== 4'b0000) begin failures++; $display("FAIL nest_iret_idle got=%b exp=0000", in_service); end
    endtask

    task automatic test_mask;
        start();
        cfg_write(4'd4, 8'h02);
        pulse_irq(4'b0010);
        pulse_boundary();
        checks++;
        if ({bus.irq_req, pending} !== {1'b0, 4'b0010}) begin
            failures++; $display("FAIL mask_block got=%b/%b exp=0/0010", bus.irq_req, pending);
        end
        cfg_write(4'd4, 8'h00);
        pulse_boundary();
        checks++;
        if (bus.irq_req !== 1'b1) begin failures++; $display("FAIL mask_req got=%b exp=1", bus.irq_req); end
        cfg_write(4'd4, 8'h02);
        checks++;
        if (bus.irq_req !== 1'b1) begin failures++; $display("FAIL mask_hold got=%b exp=1", bus.irq_req); end
        step();
        checks++;
        if ({bus.irq_req, bus.vec_valid, pending} !== {1'b0, 1'b0, 4'b0010}) begin
            failures++; $display("FAIL mask_withdraw got=%b/%b/%b exp=0/0/0010", bus.irq_req, bus.vec_valid, pending);
        end
        pulse_ack();
        checks++;
        if ({bus.vec_valid, pending, in_service} !== {1'b0, 4'b0010, 4'b0000}) begin
            failures++; $display("FAIL mask_stray_ack got=%b/%b/%b exp=0/0010/0000", bus.vec_valid, pending, in_service);
        end
    endtask

    task automatic test_table_write;
        start();
        pulse_irq(4'b0001);
        pulse_boundary();
        cfg_write(4'd0, 8'h07);
        pulse_ack();
        checks++;
        if ({bus.vec_valid, bus.vector} !== {1'b1, 4'd7}) begin
            failures++; $display("FAIL table_write got=%b/%0d exp=1/7", bus.vec_valid, bus.vector);
        end
    endtask

    task automatic test_set_wins;
        start();
        pulse_irq(4'b0001);
        pulse_boundary();
        irq_in = 4'b0001;
        step();
        irq_in = 4'b0000;
        step();
        pulse_ack();
        checks++;
        if ({bus.vec_valid, pending, in_service} !== {1'b1, 4'b0001, 4'b0001}) begin
            failures++; $display("FAIL set_wins got=%b/%b/%b exp=1/0001/0001", bus.vec_valid, pending, in_service);
        end
    endtask

    task automatic test_iret_with_ack;
        start();
        pulse_irq(4'b0100);
        pulse_boundary();
        pulse_ack();
        pulse_irq(4'b0001);
        pulse_boundary();
        bus.irq_ack = 1'b1; bus.iret = 1'b1;
        step();
        bus.irq_ack = 1'b0; bus.iret = 1'b0;
        checks++;
        if ({bus.vector, in_service} !== {4'd12, 4'b0001}) begin
            failures++; $display("FAIL iret_with_ack got=%0d/%b exp=12/0001", bus.vector, in_service);
        end
    endtask

    task automatic test_reset_mid;
        start();
        pulse_irq(4'b0100);
        pulse_boundary();
        checks++;
        if (bus.irq_req !== 1'b1) begin failures++; $display("FAIL rstmid_req got=%b exp=1", bus.irq_req); end
        rst = 1'b1; step(); rst = 1'b0;
        checks++;
        if ({bus.irq_req, bus.vec_valid, bus.vector, pending, in_service} !== 15'h0) begin
            failures++; $display("FAIL rstmid_outputs got=%0h exp=0", {bus.irq_req, bus.vec_valid, bus.vector, pending, in_service});
        end
        pulse_ack();
        checks++;
        if ({bus.vec_valid, in_service} !== {1'b0, 4'b0000}) begin
            failures++; $display("FAIL rstmid_ack got=%b/%b exp=0/0000", bus.vec_valid, in_service);
        end
        pulse_irq(4'b0010);
        pulse_boundary();
        checks++;
        if ({bus.irq_req, pending} !== {1'b0, 4'b0010}) begin
            failures++; $display("FAIL rstmid_mask got=%b/%b exp=0/0010", bus.irq_req, pending);
        end
    endtask

    initial begin
        rst = 1'b1;
        irq_in = 4'b0000;
        bus.cfg_we = 1'b0; bus.cfg_addr = 4'd0; bus.cfg_wdata = 8'h00;
        bus.boundary = 1'b0; bus.irq_ack = 1'b0; bus.iret = 1'b0;
        test_reset();
        test_basic();
        test_priority();
        test_nesting();
        test_mask();
        test_table_write();
        test_set_wins();
        test_iret_with_ack();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
